sik_mem_arbiter: RTL and testbench

Single-port memory arbiter sharing the processor's one `MEMSIZE memory between the two hardware threads of the pipelined SIK core. Four requesters: instruction fetch for thread 0 and thread 1, and data load/store for thread 0 and thread 1. The arbiter serialises them onto one fixed-latency memory port and returns the read data or a write acknowledge to the winning requester. It sits between the core's fetch/memory stages and the memory array.

---
 rtl/sik_mem_arbiter_pkg.sv | 19 +
 rtl/sik_mem_arbiter_if.sv | 31 +++
 rtl/sik_mem_arbiter_rr_pick.sv | 23 ++
 rtl/sik_mem_arbiter.sv | 118 +++++++++++
 tb/tb_sik_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sik_mem_arbiter_pkg.sv
// Shared types and constants for the SIK single-port memory arbiter.
package sik_mem_arbiter_pkg;

  localparam int unsigned WORD = 16;
  localparam int unsigned NREQ = 4;

  localparam int unsigned RQ_F0 = 0;
  localparam int unsigned RQ_F1 = 1;
  localparam int unsigned RQ_D0 = 2;
  localparam int unsigned RQ_D1 = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sik_mem_arbiter_if.sv
// Requester and memory-port bundle between the SIK core stages, the arbiter and the memory.
interface sik_mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) ();

  logic [3:0]      req;
  logic [3:0]      req_we;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]      gnt;
  logic [3:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/sik_mem_arbiter_rr_pick.sv
// Winner selection: data class beats fetch class, round-robin between threads inside a class.
module sik_rr_pick
  import sik_mem_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_last_thread,
  output logic [NREQ-1:0] o_win_c,
  output logic            o_thread_c
);

  logic       w_data;
  logic [1:0] w_cls;

  always_comb begin
    w_data     = i_req[RQ_D0] | i_req[RQ_D1];
    w_cls      = w_data ? i_req[RQ_D1:RQ_D0] : i_req[RQ_F1:RQ_F0];
    o_thread_c = (w_cls == 2'b11) ? ~i_last_thread : w_cls[1];
    o_win_c    = '0;
    // Requester index is {class, thread}: F0=0, F1=1, D0=2, D1=3.
    if (|w_cls) o_win_c[{w_data, o_thread_c}] = 1'b1;
  end

endmodule

// File: rtl/sik_mem_arbiter.sv
// Serialises four requesters (fetch/data x two threads) onto one fixed-latency memory port.
module sik_mem_arbiter
  import sik_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW  = WORD,
  parameter int unsigned DW  = WORD,
  parameter int unsigned LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  sik_mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CNT_INIT = (LAT > 1) ? LAT - 2 : 0;

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_thread;
  logic [NREQ-1:0]  r_win;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rsp_valid;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;

  logic [NREQ-1:0]  w_win;
  logic             w_thread;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;
  logic             w_we;

  sik_rr_pick u_pick (
    .i_req         (bus.req),
    .i_last_thread (r_last_thread),
    .o_win_c       (w_win),
    .o_thread_c    (w_thread)
  );

  // Select the winner's payload; fetch requesters can never write.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_addr  = bus.req_addr[i*AW +: AW];
        w_wdata = bus.req_wdata[i*DW +: DW];
        w_we    = bus.req_we[i] & (i >= RQ_D0);
      end
    end
  end

  // Strobes default low each cycle; address/data hold their captured values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ARB_IDLE;
      r_cnt         <= '0;
      r_last_thread <= 1'b1;
      r_win         <= '0;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (|bus.req) begin
            r_state       <= ARB_ISSUE;
            r_win         <= w_win;
            r_gnt         <= w_win;
            r_last_thread <= w_thread;
            r_mem_en      <= 1'b1;
            r_mem_we      <= w_we;
            r_mem_addr    <= w_addr;
            r_mem_wdata   <= w_wdata;
          end
        end
        ARB_ISSUE: begin
          if (LAT <= 1) begin
            r_state     <= ARB_RESP;
            r_rsp_valid <= r_win;
          end else begin
            r_state <= ARB_WAIT;
            r_cnt   <= CNT_W'(CNT_INIT);
          end
        end
        ARB_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= ARB_RESP;
            r_rsp_valid <= r_win;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ARB_RESP: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = (|r_rsp_valid) ? bus.mem_rdata : '0;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_sik_mem_arbiter.sv
// Directed bench for sik_mem_arbiter at LAT=1, 3 and 4 with a simple latency-pipelined memory.
module tb_sik_mem_arbiter;
  import sik_mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  logic [15:0]       mem [256];
  logic [3:0][15:0]  rp1, rp3, rp4;

  sik_mem_arbiter_if #(.AW(16), .DW(16)) b1 ();
  sik_mem_arbiter_if #(.AW(16), .DW(16)) b3 ();
  sik_mem_arbiter_if #(.AW(16), .DW(16)) b4 ();

  sik_mem_arbiter #(.AW(16), .DW(16), .LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  sik_mem_arbiter #(.AW(16), .DW(16), .LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  sik_mem_arbiter #(.AW(16), .DW(16), .LAT(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data appears LAT edges after the edge that samples mem_en.
  always @(posedge clk) begin
    rp1 <= {rp1[2:0], b1.mem_en ? mem[b1.mem_addr[7:0]] : 16'hDEAD};
    rp3 <= {rp3[2:0], b3.mem_en ? mem[b3.mem_addr[7:0]] : 16'hDEAD};
    rp4 <= {rp4[2:0], b4.mem_en ? mem[b4.mem_addr[7:0]] : 16'hDEAD};
    if (b1.mem_en && b1.mem_we) mem[b1.mem_addr[7:0]] <= b1.mem_wdata;
  end
  assign b1.mem_rdata = rp1[0];
  assign b3.mem_rdata = rp3[2];
  assign b4.mem_rdata = rp4[3];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic inv(input string n, input logic [3:0] g, input logic [3:0] r,
                     input logic en, input logic we, input logic iss);
    chk({n, "_gnt_onehot"}, 32'($onehot0(g)), 32'd1);
    chk({n, "_rsp_onehot"}, 32'($onehot0(r)), 32'd1);
    chk({n, "_we_needs_en"}, 32'(!we || en), 32'd1);
    chk({n, "_en_only_issue"}, 32'(!en || iss), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      inv("b1", b1.gnt, b1.rsp_valid, b1.mem_en, b1.mem_we, u1.r_state == ARB_ISSUE);
      inv("b3", b3.gnt, b3.rsp_valid, b3.mem_en, b3.mem_we, u3.r_state == ARB_ISSUE);
      inv("b4", b4.gnt, b4.rsp_valid, b4.mem_en, b4.mem_we, u4.r_state == ARB_ISSUE);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  ord [4];
  logic [15:0] ord_data [4];
  logic        ord_lt [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    b1.req = '0; b1.req_we = '0; b1.req_addr = '0; b1.req_wdata = '0;
    b3.req = '0; b3.req_we = '0; b3.req_addr = '0; b3.req_wdata = '0;
    b4.req = '0; b4.req_we = '0; b4.req_addr = '0; b4.req_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'hA5A5;
    mem[8'h11] = 16'hB0B1;
    mem[8'h12] = 16'hD0D0;
    mem[8'h13] = 16'hD1D1;
    mem[8'h20] = 16'hBEEF;
    ord      = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ord_data = '{16'hD0D0, 16'hD1D1, 16'hA5A5, 16'hB0B1};
    ord_lt   = '{1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) tick();
    chk("rst_gnt", 32'(b1.gnt), 32'h0);
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'h0);
    chk("rst_mem_en", 32'(b1.mem_en), 32'h0);
    chk("rst_mem_we", 32'(b1.mem_we), 32'h0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(b1.mem_wdata), 32'h0);
    chk("rst_rsp_data", 32'(b1.rsp_data), 32'h0);
    chk("rst_busy", 32'(b1.busy), 32'h0);
    chk("rst_last_thread", 32'(u1.r_last_thread), 32'h1);
    reset = 1'b1;

    // Single fetch, LAT=1
    b1.req_addr[0 +: 16] = 16'h0010;
    b1.req = 4'b0001;
    tick();
    chk("t1_gnt", 32'(b1.gnt), 32'h1);
    chk("t1_mem_en", 32'(b1.mem_en), 32'h1);
    chk("t1_mem_we", 32'(b1.mem_we), 32'h0);
    chk("t1_mem_addr", 32'(b1.mem_addr), 32'h0010);
    chk("t1_busy", 32'(b1.busy), 32'h1);
    tick();
    chk("t1_gnt_off", 32'(b1.gnt), 32'h0);
    chk("t1_mem_en_off", 32'(b1.mem_en), 32'h0);
    chk("t1_rsp_valid", 32'(b1.rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(b1.rsp_data), 32'hA5A5);
    b1.req = '0;
    tick();
    chk("t1_rsp_off", 32'(b1.rsp_valid), 32'h0);
    chk("t1_busy_low", 32'(b1.busy), 32'h0);

    // All four requesting: data first, round-robin within class
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    b1.req_addr = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    b1.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t2_gnt%0d", k), 32'(b1.gnt), 32'(ord[k]));
      chk($sformatf("t2_last%0d", k), 32'(u1.r_last_thread), 32'(ord_lt[k]));
      tick();
      chk($sformatf("t2_rsp%0d", k), 32'(b1.rsp_valid), 32'(ord[k]));
      chk($sformatf("t2_data%0d", k), 32'(b1.rsp_data), 32'(ord_data[k]));
      b1.req = b1.req & ~ord[k];
      tick();
    end

    // Store on D0, then a fetch with a stray write enable
    b1.req_addr[32 +: 16]  = 16'h00FF;
    b1.req_wdata[32 +: 16] = 16'h1234;
    b1.req_we = 4'b0100;
    b1.req    = 4'b0100;
    tick();
    chk("t3_gnt", 32'(b1.gnt), 32'h4);
    chk("t3_mem_en", 32'(b1.mem_en), 32'h1);
    chk("t3_mem_we", 32'(b1.mem_we), 32'h1);
    chk("t3_mem_addr", 32'(b1.mem_addr), 32'h00FF);
    chk("t3_mem_wdata", 32'(b1.mem_wdata), 32'h1234);
    tick();
    chk("t3_ack", 32'(b1.rsp_valid), 32'h4);
    b1.req = '0;
    b1.req_we = '0;
    tick();
    chk("t3_mem_written", 32'(mem[8'hFF]), 32'h1234);
    b1.req_we = 4'b0001;
    b1.req    = 4'b0001;
    tick();
    chk("t3_fetch_en", 32'(b1.mem_en), 32'h1);
    chk("t3_fetch_no_we", 32'(b1.mem_we), 32'h0);
    tick();
    chk("t3_fetch_rsp", 32'(b1.rsp_valid), 32'h1);
    b1.req = '0;
    b1.req_we = '0;
    tick();

    // LAT=3 fetch on thread 1: two WAIT cycles
    b3.req_addr[16 +: 16] = 16'h0020;
    b3.req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(b3.gnt), 32'h2);
    chk("t4_mem_en", 32'(b3.mem_en), 32'h1);
    for (int w = 0; w < 2; w++) begin
      tick();
      chk($sformatf("t4_wait_state%0d", w), 32'(u3.r_state), 32'(ARB_WAIT));
      chk($sformatf("t4_wait_rsp%0d", w), 32'(b3.rsp_valid), 32'h0);
      chk($sformatf("t4_wait_en%0d", w), 32'(b3.mem_en), 32'h0);
    end
    tick();
    chk("t4_rsp", 32'(b3.rsp_valid), 32'h2);
    chk("t4_data", 32'(b3.rsp_data), 32'hBEEF);
    b3.req = '0;
    tick();
    chk("t4_busy_low", 32'(b3.busy), 32'h0);

    // LAT=4: reset mid-WAIT discards the transaction, then it restarts
    b4.req_addr[16 +: 16] = 16'h0020;
    b4.req = 4'b0010;
    tick();
    chk("t5_gnt", 32'(b4.gnt), 32'h2);
    tick();
    chk("t5_in_wait", 32'(u4.r_state), 32'(ARB_WAIT));
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(b4.busy), 32'h0);
    chk("t5_rst_gnt", 32'(b4.gnt), 32'h0);
    chk("t5_rst_rsp", 32'(b4.rsp_valid), 32'h0);
    chk("t5_rst_en", 32'(b4.mem_en), 32'h0);
    chk("t5_rst_addr", 32'(b4.mem_addr), 32'h0);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk($sformatf("t5_no_rsp%0d", r), 32'(b4.rsp_valid), 32'h0);
    end
    reset = 1'b1;
    tick();
    chk("t5_regnt", 32'(b4.gnt), 32'h2);
    chk("t5_regnt_en", 32'(b4.mem_en), 32'h1);
    chk("t5_regnt_addr", 32'(b4.mem_addr), 32'h0020);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk($sformatf("t5_wait_rsp%0d", w), 32'(b4.rsp_valid), 32'h0);
    end
    tick();
    chk("t5_rsp", 32'(b4.rsp_valid), 32'h2);
    chk("t5_data", 32'(b4.rsp_data), 32'hBEEF);
    b4.req = '0;
    tick();

    // LAT=3: D1 arrives during F0's WAIT and is served next
    b3.req_addr[0 +: 16] = 16'h0010;
    b3.req = 4'b0001;
    tick();
    chk("t6_gnt_f0", 32'(b3.gnt), 32'h1);
    tick();
    b3.req_addr[48 +: 16] = 16'h0013;
    b3.req = 4'b1001;
    tick();
    chk("t6_no_preempt", 32'(b3.gnt), 32'h0);
    tick();
    chk("t6_rsp_f0", 32'(b3.rsp_valid), 32'h1);
    chk("t6_data_f0", 32'(b3.rsp_data), 32'hA5A5);
    b3.req = 4'b1000;
    tick();
    chk("t6_idle_gap", 32'(b3.gnt), 32'h0);
    tick();
    chk("t6_gnt_d1", 32'(b3.gnt), 32'h8);
    chk("t6_addr_d1", 32'(b3.mem_addr), 32'h0013);
    repeat (3) tick();
    chk("t6_rsp_d1", 32'(b3.rsp_valid), 32'h8);
    chk("t6_data_d1", 32'(b3.rsp_data), 32'hD1D1);
    b3.req = '0;
    repeat (2) tick();
    chk("t6_quiet_gnt", 32'(b3.gnt), 32'h0);
    chk("t6_quiet_busy", 32'(b3.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
